dmem_port_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single data-memory port. Master 0 is the
//  CPU load/store unit; master 1 is the debug/loader port. Latches one request per

---
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter/sequencer for the single data-memory port: latches one request per
// grant, screens alignment/range, drives the memory bus for one cycle, then returns data/error.
module dmem_port_arbiter #(
  parameter int DEPTH      = 256,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [2:0]  m0_rw_type,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [2:0]  m1_rw_type,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_rw_type,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [30:0] DEPTH_W = 31'(DEPTH);

  state_t      state_q, state_d;
  logic        last_grant_q, idx_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  type_q;

  logic        win, latch_en, sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_type;

  // Winner selection and request screening happen on the raw inputs, ahead of the latch.
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    sel_we    = win ? m1_we      : m0_we;
    sel_addr  = win ? m1_addr    : m0_addr;
    sel_type  = win ? m1_rw_type : m0_rw_type;
    sel_wdata = win ? m1_wdata   : m0_wdata;
    case (sel_type[1:0])
      2'b01:   sel_err = sel_addr[0];
      2'b10:   sel_err = |sel_addr[1:0];
      2'b11:   sel_err = 1'b1;
      default: sel_err = 1'b0;
    endcase
    if ({1'b0, sel_addr[31:2]} >= DEPTH_W) sel_err = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    latch_en    = 1'b0;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = addr_q;
    mem_rw_type = type_q;
    mem_data_in = wdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (state_q == S_RESP) begin
          m0_rvalid = ~idx_q;
          m1_rvalid = idx_q;
          m0_rdata  = idx_q ? '0 : rdata_q;
          m1_rdata  = idx_q ? rdata_q : '0;
          m0_err    = ~idx_q & err_q;
          m1_err    = idx_q & err_q;
        end
        if (m0_req || m1_req) begin
          latch_en = 1'b1;
          state_d  = S_ACCESS;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d   = S_RESP;
        m0_gnt    = ~idx_q;
        m1_gnt    = idx_q;
        mem_wr_en = we_q & ~err_q;
        mem_rd_en = ~we_q & ~err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      type_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        idx_q        <= win;
        last_grant_q <= win;
        we_q         <= sel_we;
        err_q        <= sel_err;
        addr_q       <= sel_addr;
        type_q       <= sel_type;
        wdata_q      <= sel_wdata;
      end
      // Read data is sampled at the same edge the store commits; stores and errors return 0.
      if (state_q == S_ACCESS) rdata_q <= (~we_q & ~err_q) ? mem_data_out : '0;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural byte memory plus an access-level reference model.
module tb_dmem_port_arbiter;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst, mem_clr;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_rw_type, m1_rw_type;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [2:0]  mem_rw_type;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_mem_wr_en, fp_mem_rd_en;
  logic [31:0] fp_mem_addr, fp_mem_data_in;
  logic [2:0]  fp_mem_rw_type;

  dmem_port_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_rw_type(m0_rw_type), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_rw_type(m1_rw_type), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rw_type(mem_rw_type),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  dmem_port_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_rw_type(m0_rw_type), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_rw_type(m1_rw_type), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .mem_wr_en(fp_mem_wr_en), .mem_rd_en(fp_mem_rd_en), .mem_addr(fp_mem_addr),
    .mem_rw_type(fp_mem_rw_type), .mem_data_in(fp_mem_data_in), .mem_data_out(32'h0)
  );

  function automatic logic [31:0] ext(input logic [7:0] b0, b1, b2, b3, input logic [2:0] t);
    case (t[1:0])
      2'b00:   ext = t[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   ext = t[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: ext = {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic [7:0] init_val(input int i);
    init_val = 8'(i * 37 + 11);
  endfunction

  // Memory device emulation driven by the DUT's bus.
  logic [7:0] emu [NB];
  logic [9:0] ea;
  assign ea = mem_addr[9:0];
  assign mem_data_out = ext(emu[ea], emu[ea + 10'd1], emu[ea + 10'd2], emu[ea + 10'd3], mem_rw_type);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NB; i++) emu[i] <= init_val(i);
    end else if (mem_wr_en) begin
      emu[ea] <= mem_data_in[7:0];
      if (mem_rw_type[1:0] != 2'b00) emu[ea + 10'd1] <= mem_data_in[15:8];
      if (mem_rw_type[1]) begin
        emu[ea + 10'd2] <= mem_data_in[23:16];
        emu[ea + 10'd3] <= mem_data_in[31:24];
      end
    end
  end

  // Reference model state: expected memory contents and who was granted last.
  logic [7:0] ref_mem [NB];
  logic       model_last;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_access(input logic m, input logic we, input logic [31:0] addr,
                           input logic [2:0] t, input logic [31:0] wd,
                           output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [9:0]  a;
    exp_err = (t[1:0] == 2'b11) || (t[1:0] == 2'b01 && addr[0]) ||
              (t[1:0] == 2'b10 && addr[1:0] != 2'b00) || ((addr / 4) >= DEPTH);
    exp_rd = '0;
    a = addr[9:0];
    if (!exp_err) begin
      if (we) begin
        ref_mem[a] = wd[7:0];
        if (t[1:0] != 2'b00) ref_mem[a + 10'd1] = wd[15:8];
        if (t[1]) begin
          ref_mem[a + 10'd2] = wd[23:16];
          ref_mem[a + 10'd3] = wd[31:24];
        end
      end else begin
        exp_rd = ext(ref_mem[a], ref_mem[a + 10'd1], ref_mem[a + 10'd2], ref_mem[a + 10'd3], t);
      end
    end
    @(negedge clk);
    if (!m) begin
      m0_we = we; m0_addr = addr; m0_rw_type = t; m0_wdata = wd; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_rw_type = t; m1_wdata = wd; m1_req = 1'b1;
    end
    @(posedge clk); #1;
    chk("gnt0", 32'(m0_gnt), 32'(!m));
    chk("gnt1", 32'(m1_gnt), 32'(m));
    chk("wr_en", 32'(mem_wr_en), 32'(we && !exp_err));
    chk("rd_en", 32'(mem_rd_en), 32'(!we && !exp_err));
    chk("mem_addr", mem_addr, addr);
    chk("mem_type", 32'(mem_rw_type), 32'(t));
    if (we) chk("mem_wdata", mem_data_in, wd);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge clk); #1;
    chk("rvalid0", 32'(m0_rvalid), 32'(!m));
    chk("rvalid1", 32'(m1_rvalid), 32'(m));
    got_rd  = m ? m1_rdata : m0_rdata;
    got_err = m ? m1_err : m0_err;
    chk("rdata", got_rd, exp_rd);
    chk("err", 32'(got_err), 32'(exp_err));
    model_last = m;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        w, prev_w;

  initial begin
    for (int i = 0; i < NB; i++) ref_mem[i] = init_val(i);
    model_last = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_rw_type = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_rw_type = 0; m1_wdata = 0;
    rst = 1'b1; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 32'(|{m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                          mem_wr_en, mem_rd_en, mem_addr, mem_rw_type, mem_data_in}), 32'h0);
    chk("rst_fp", 32'(|{fp_m0_gnt, fp_m0_rvalid, fp_m0_rdata, fp_m0_err, fp_m1_gnt, fp_m1_rvalid,
                        fp_m1_rdata, fp_m1_err, fp_mem_wr_en, fp_mem_rd_en, fp_mem_addr,
                        fp_mem_rw_type, fp_mem_data_in}), 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;

    // Store then load a word.
    do_access(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er);
    do_access(1'b0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er);
    chk("t1_rdata", rd, 32'hDEADBEEF);

    // Misaligned and out-of-range screening.
    do_access(1'b1, 1'b0, 32'h13, 3'b001, 32'h0, rd, er);
    chk("t3_half_err", 32'(er), 32'h1);
    do_access(1'b1, 1'b0, 32'h12, 3'b010, 32'h0, rd, er);
    chk("t3_word_err", 32'(er), 32'h1);
    do_access(1'b0, 1'b0, 32'h400, 3'b010, 32'h0, rd, er);
    chk("t4_oor_err", 32'(er), 32'h1);
    do_access(1'b0, 1'b0, 32'h3FC, 3'b010, 32'h0, rd, er);
    chk("t4_top_err", 32'(er), 32'h0);

    // Byte store then signed and unsigned byte loads.
    do_access(1'b1, 1'b1, 32'h21, 3'b000, 32'h80, rd, er);
    do_access(1'b1, 1'b0, 32'h21, 3'b000, 32'h0, rd, er);
    chk("t5_sext", rd, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 32'h21, 3'b100, 32'h0, rd, er);
    chk("t5_zext", rd, 32'h00000080);

    // Contention with both requests held.
    @(negedge clk);
    m0_we = 0; m0_addr = 32'h10; m0_rw_type = 3'b010; m0_req = 1'b1;
    m1_we = 0; m1_addr = 32'h14; m1_rw_type = 3'b010; m1_req = 1'b1;
    prev_w = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 1) begin
        w = ~model_last;
        model_last = w;
        prev_w = w;
        chk("arb_g0", 32'(m0_gnt), 32'(!w));
        chk("arb_g1", 32'(m1_gnt), 32'(w));
        chk("fp_g0", 32'(fp_m0_gnt), 32'h1);
        chk("fp_g1", 32'(fp_m1_gnt), 32'h0);
      end else begin
        chk("arb_idle", 32'({m0_gnt, m1_gnt}), 32'h0);
        chk("arb_rv", 32'({m1_rvalid, m0_rvalid}), prev_w ? 32'h2 : 32'h1);
        chk("arb_rd", prev_w ? m1_rdata : m0_rdata,
            prev_w ? {ref_mem[23], ref_mem[22], ref_mem[21], ref_mem[20]}
                   : {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
      end
    end
    m0_req = 1'b0;
    @(posedge clk); #1;
    chk("arb_m1_only", 32'(m1_gnt), 32'h1);
    chk("fp_m1_only", 32'(fp_m1_gnt), 32'h1);
    model_last = 1'b1;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a store's ACCESS cycle.
    do_access(1'b0, 1'b1, 32'h30, 3'b010, 32'hAAAA5555, rd, er);
    @(negedge clk);
    m0_we = 1; m0_addr = 32'h30; m0_rw_type = 3'b010; m0_wdata = 32'h12345678; m0_req = 1'b1;
    @(posedge clk); #1;
    chk("t6_wr_en", 32'(mem_wr_en), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_outs", 32'(|{m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                         mem_wr_en, mem_rd_en, mem_addr, mem_rw_type, mem_data_in}), 32'h0);
    m0_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t6_no_rv", 32'({m0_rvalid, m1_rvalid}), 32'h0);
    end
    do_access(1'b0, 1'b0, 32'h30, 3'b010, 32'h0, rd, er);
    chk("t6_old", rd, 32'hAAAA5555);

    // Randomized single-requester traffic against the model.
    for (int i = 0; i < 80; i++) begin
      int          widx;
      int          off;
      logic [31:0] a;
      widx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH - 2, DEPTH + 2))
                                         : int'($urandom_range(0, 15));
      off  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      a    = 32'(widx * 4 + off);
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                3'($urandom_range(0, 7)), $urandom, rd, er);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
